// File: rtl/ram_port_arbiter.sv
// Two-master (instruction/data) arbiter in front of a single-port RAM, with a wait timeout.
// Define ARB_ROUND_ROBIN_EN to alternate grants on ties; otherwise data always wins a tie.
module ram_port_arbiter #(
    parameter int dataW         = 32,
    parameter int RAMAddrSize   = 16,
    parameter int TimeoutCycles = 255
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   ins_req,
    input  logic [dataW-1:0]       ins_addr,
    input  logic                   data_req,
    input  logic [dataW-1:0]       data_addr,
    input  logic                   data_we,
    input  logic [dataW-1:0]       data_wdata,
    output logic                   ins_done,
    output logic                   data_done,
    output logic [dataW-1:0]       rdata,
    output logic                   err,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [RAMAddrSize-1:0] mem_addr,
    output logic [dataW-1:0]       mem_wdata,
    input  logic                   mem_ready,
    input  logic [dataW-1:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    localparam logic [7:0] WaitLast = 8'(TimeoutCycles - 1);

    state_t                 state_q, state_d;
    logic                   mem_we_q, mem_we_d;
    logic [RAMAddrSize-1:0] mem_addr_q, mem_addr_d;
    logic [dataW-1:0]       mem_wdata_q, mem_wdata_d;
    logic [dataW-1:0]       rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic                   ins_done_q, ins_done_d;
    logic                   data_done_q, data_done_d;
    logic [7:0]             wait_q, wait_d;
    logic                   prefer_data;
    logic                   any_done;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = data was granted most recently
    logic last_grant_q, last_grant_d;
    assign prefer_data = ~last_grant_q;
`else
    assign prefer_data = 1'b1;
`endif

    assign any_done = ins_done_q | data_done_q;

    always_comb begin
        state_d     = state_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        wait_d      = wait_q;
        ins_done_d  = 1'b0;
        data_done_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                // No grant while any done is showing: the finishing master's req is still up.
                if (!any_done && (ins_req || data_req)) begin
                    wait_d = 8'd0;
                    if (data_req && (!ins_req || prefer_data)) begin
                        state_d     = BUSY_D;
                        mem_we_d    = data_we;
                        mem_addr_d  = data_addr[RAMAddrSize-1:0];
                        mem_wdata_d = data_wdata;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant_d = 1'b1;
`endif
                    end else begin
                        state_d     = BUSY_I;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = ins_addr[RAMAddrSize-1:0];
                        mem_wdata_d = '0;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant_d = 1'b0;
`endif
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready) begin
                    rdata_d     = mem_rdata;
                    err_d       = 1'b0;
                    state_d     = IDLE;
                    mem_we_d    = 1'b0;
                    ins_done_d  = (state_q == BUSY_I);
                    data_done_d = (state_q == BUSY_D);
                end else if (wait_q == WaitLast) begin
                    rdata_d     = '0;
                    err_d       = 1'b1;
                    state_d     = IDLE;
                    mem_we_d    = 1'b0;
                    ins_done_d  = (state_q == BUSY_I);
                    data_done_d = (state_q == BUSY_D);
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            ins_done_q  <= 1'b0;
            data_done_q <= 1'b0;
            wait_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            ins_done_q  <= ins_done_d;
            data_done_q <= data_done_d;
            wait_q      <= wait_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clock) begin
        if (!reset) last_grant_q <= 1'b0;
        else        last_grant_q <= last_grant_d;
    end
`endif

    // Upper address bits are outside the RAM window and intentionally dropped.
    generate
        if (RAMAddrSize < dataW) begin : g_addr_trim
            logic unused_addr_hi;
            assign unused_addr_hi = ^{ins_addr[dataW-1:RAMAddrSize], data_addr[dataW-1:RAMAddrSize]};
        end
    endgenerate

    assign mem_req   = (state_q != IDLE);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign ins_done  = ins_done_q;
    assign data_done = data_done_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: load, store, timeout, tie arbitration, reset abort, held req.
module tb_ram_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          ins_req, data_req, data_we, mem_ready;
    logic [DW-1:0] ins_addr, data_addr, data_wdata, mem_rdata;
    logic          ins_done, data_done, err, mem_req, mem_we;
    logic [DW-1:0] rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    int errors = 0;
    int checks = 0;

    ram_port_arbiter #(.dataW(DW), .RAMAddrSize(AW), .TimeoutCycles(4)) dut (
        .clock(clock), .reset(reset),
        .ins_req(ins_req), .ins_addr(ins_addr),
        .data_req(data_req), .data_addr(data_addr), .data_we(data_we), .data_wdata(data_wdata),
        .ins_done(ins_done), .data_done(data_done), .rdata(rdata), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
        checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", err); end
        checks++; if ({ins_done, data_done} !== 2'b00) begin errors++; $display("FAIL rst_done got=%b exp=00", {ins_done, data_done}); end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_load();
        data_req = 1'b1; data_addr = 32'h0000_0010; data_we = 1'b0;
        @(negedge clock);
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL load_mem_req got=%b exp=1", mem_req); end
        checks++; if (mem_addr !== 16'h0010) begin errors++; $display("FAIL load_mem_addr got=%h exp=0010", mem_addr); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL load_mem_we got=%b exp=0", mem_we); end
        mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clock);
        checks++; if (data_done !== 1'b1) begin errors++; $display("FAIL load_done got=%b exp=1", data_done); end
        checks++; if (rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_rdata got=%h exp=deadbeef", rdata); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL load_err got=%b exp=0", err); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL load_mem_req_off got=%b exp=0", mem_req); end
        data_req = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h1111_2222;
        @(negedge clock);
        checks++; if (data_done !== 1'b0) begin errors++; $display("FAIL load_done_pulse got=%b exp=0", data_done); end
        checks++; if (rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_rdata_hold got=%h exp=deadbeef", rdata); end
    endtask

    task automatic test_store();
        data_req = 1'b1; data_we = 1'b1; data_wdata = 32'h1234_5678; data_addr = 32'h0000_0100;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL store_mem_req[%0d] got=%b exp=1", i, mem_req); end
            checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL store_mem_we[%0d] got=%b exp=1", i, mem_we); end
            checks++; if (mem_wdata !== 32'h1234_5678) begin errors++; $display("FAIL store_wdata[%0d] got=%h exp=12345678", i, mem_wdata); end
            checks++; if (data_done !== 1'b0) begin errors++; $display("FAIL store_early_done[%0d] got=%b exp=0", i, data_done); end
            if (i == 3) begin mem_ready = 1'b1; mem_rdata = 32'hA5A5_A5A5; end
        end
        @(negedge clock);
        checks++; if (data_done !== 1'b1) begin errors++; $display("FAIL store_done got=%b exp=1", data_done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL store_err got=%b exp=0", err); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL store_we_off got=%b exp=0", mem_we); end
        checks++; if (mem_addr !== 16'h0100) begin errors++; $display("FAIL store_addr got=%h exp=0100", mem_addr); end
        data_req = 1'b0; data_we = 1'b0; mem_ready = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_timeout();
        int  hi_cycles = 0;
        bit  seen = 1'b0;
        ins_req = 1'b1; ins_addr = 32'h0000_0040; mem_ready = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clock);
            if (mem_req) hi_cycles++;
            if (ins_done) begin
                seen = 1'b1;
                checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err got=%b exp=1", err); end
                checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL to_rdata got=%h exp=0", rdata); end
                checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL to_idle got=%b exp=0", mem_req); end
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL to_done_wait got=none exp=ins_done within 12 cycles"); end
        checks++; if (hi_cycles != 4) begin errors++; $display("FAIL to_mem_req_cycles got=%0d exp=4", hi_cycles); end
        ins_req = 1'b0;
        @(negedge clock);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL to_stay_idle got=%b exp=0", mem_req); end
    endtask

    task automatic test_back_to_back();
        string got = "";
        string exp;
        int    nd = 0, ni = 0;
`ifdef ARB_ROUND_ROBIN_EN
        exp = "DIDIDI";
`else
        exp = "DDDIII";
`endif
        ins_req = 1'b1; ins_addr = 32'h0000_0200;
        data_req = 1'b1; data_addr = 32'h0000_0300; data_we = 1'b0;
        for (int i = 0; i < 60 && (nd < 3 || ni < 3); i++) begin
            @(negedge clock);
            checks++; if (ins_done && data_done) begin errors++; $display("FAIL b2b_both_done got=11 exp=one-hot"); end
            if (data_done) begin
                got = {got, "D"}; nd++;
                checks++; if (rdata !== 32'hC0DE_0300) begin errors++; $display("FAIL b2b_d_rdata got=%h exp=c0de0300", rdata); end
                if (nd == 3) data_req = 1'b0;
            end
            if (ins_done) begin
                got = {got, "I"}; ni++;
                checks++; if (rdata !== 32'hC0DE_0200) begin errors++; $display("FAIL b2b_i_rdata got=%h exp=c0de0200", rdata); end
                if (ni == 3) ins_req = 1'b0;
            end
            mem_ready = mem_req;
            mem_rdata = {16'hC0DE, mem_addr};
        end
        checks++; if (got != exp) begin errors++; $display("FAIL b2b_order got=%s exp=%s", got, exp); end
        ins_req = 1'b0; data_req = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset_midflight();
        data_req = 1'b1; data_addr = 32'h0000_0080; data_we = 1'b0; mem_ready = 1'b0;
        @(negedge clock);
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rmf_busy got=%b exp=1", mem_req); end
        reset = 1'b0;
        @(negedge clock);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rmf_abort got=%b exp=0", mem_req); end
        checks++; if (data_done !== 1'b0) begin errors++; $display("FAIL rmf_no_done got=%b exp=0", data_done); end
        reset = 1'b1;
        @(negedge clock);
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rmf_restart got=%b exp=1", mem_req); end
        checks++; if (mem_addr !== 16'h0080) begin errors++; $display("FAIL rmf_addr got=%h exp=0080", mem_addr); end
        mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
        @(negedge clock);
        checks++; if (data_done !== 1'b1) begin errors++; $display("FAIL rmf_done got=%b exp=1", data_done); end
        data_req = 1'b0; mem_ready = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_req_held();
        data_req = 1'b1; data_addr = 32'h0000_0020; data_we = 1'b0;
        @(negedge clock);
        mem_ready = 1'b1; mem_rdata = 32'h5555_AAAA;
        @(negedge clock);
        checks++; if (data_done !== 1'b1) begin errors++; $display("FAIL held_done got=%b exp=1", data_done); end
        mem_ready = 1'b0;
        @(negedge clock);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL held_no_grant got=%b exp=0", mem_req); end
        checks++; if (data_done !== 1'b0) begin errors++; $display("FAIL held_done_pulse got=%b exp=0", data_done); end
        @(negedge clock);
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL held_regrant got=%b exp=1", mem_req); end
        mem_ready = 1'b1;
        @(negedge clock);
        data_req = 1'b0; mem_ready = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b0; ins_req = 1'b0; data_req = 1'b0; data_we = 1'b0; mem_ready = 1'b0;
        ins_addr = '0; data_addr = '0; data_wdata = '0; mem_rdata = '0;
        test_reset();
        test_load();
        test_store();
        test_timeout();
        test_back_to_back();
        test_reset_midflight();
        test_req_held();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
